// File: rtl/exec_writeback_pkg.sv
// Shared definitions for the execute/write-back stage: opcode classes,
// ALU and branch funct3 encodings, and the load FSM state type.
package exec_writeback_pkg;

    localparam int XLEN = 64;

    // Major opcodes of the instruction classes this stage executes
    localparam logic [6:0] ALGORITHM     = 7'b0110011;
    localparam logic [6:0] ALGORITHM_IMM = 7'b0010011;
    localparam logic [6:0] LOAD          = 7'b0000011;
    localparam logic [6:0] BRANCH        = 7'b1100011;

    // ALU funct3 encodings
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3 encodings (010/011 are never taken)
    localparam logic [2:0] B_EQ  = 3'b000;
    localparam logic [2:0] B_NE  = 3'b001;
    localparam logic [2:0] B_LT  = 3'b100;
    localparam logic [2:0] B_GE  = 3'b101;
    localparam logic [2:0] B_LTU = 3'b110;
    localparam logic [2:0] B_GEU = 3'b111;

    // Load sequencing states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/exec_writeback_if.sv
// Decode bundle, load handshake, write-back and branch-resolution signals.
// Load handshake: mem_req/mem_addr are held stable until a cycle in which
// mem_ack=1 is sampled on the rising edge; that cycle completes the
// transfer and mem_rdata is taken in the same cycle.
interface exec_writeback_if;
    import exec_writeback_pkg::*;

    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            write_back;
    logic            imm_flag;
    logic            mem_acc;
    logic            load_flag;
    logic            branch_flag;
    logic [XLEN-1:0] branch_offset;
    logic [XLEN-1:0] PC_i;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_value;
    logic            wb_en;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            ex_busy;

    // Execute stage side
    modport slave (
        input  rd, funct3, funct7, op1, op2, write_back, imm_flag, mem_acc,
               load_flag, branch_flag, branch_offset, PC_i, mem_rdata, mem_ack,
        output mem_req, mem_addr, wb_rd, wb_value, wb_en, branch_taken,
               branch_target, ex_busy
    );

    // Decode / memory side
    modport master (
        output rd, funct3, funct7, op1, op2, write_back, imm_flag, mem_acc,
               load_flag, branch_flag, branch_offset, PC_i, mem_rdata, mem_ack,
        input  mem_req, mem_addr, wb_rd, wb_value, wb_en, branch_taken,
               branch_target, ex_busy
    );
endinterface

// File: rtl/exec_writeback_alu.sv
// Combinational RV64I ALU plus branch comparator.
module exec_alu
    import exec_writeback_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic            funct7_5_i,
    input  logic            imm_flag_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    output logic [XLEN-1:0] result_o,
    output logic            cond_o
);
    logic [5:0] shamt;
    logic       arith;

    assign shamt = op2_i[5:0];
    // Immediate shifts carry the arithmetic selector inside the immediate
    assign arith = imm_flag_i ? op2_i[10] : funct7_5_i;

    // ALU result selected by funct3
    always_comb begin
        result_o = '0;
        case (funct3_i)
            F3_ADD:  result_o = (!imm_flag_i && funct7_5_i) ? op1_i - op2_i : op1_i + op2_i;
            F3_SLL:  result_o = op1_i << shamt;
            F3_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
            F3_SLTU: result_o = {{(XLEN-1){1'b0}}, op1_i < op2_i};
            F3_XOR:  result_o = op1_i ^ op2_i;
            F3_SR:   result_o = arith ? $unsigned($signed(op1_i) >>> shamt) : op1_i >> shamt;
            F3_OR:   result_o = op1_i | op2_i;
            F3_AND:  result_o = op1_i & op2_i;
            default: result_o = '0;
        endcase
    end

    // Branch condition selected by funct3
    always_comb begin
        cond_o = 1'b0;
        case (funct3_i)
            B_EQ:    cond_o = (op1_i == op2_i);
            B_NE:    cond_o = (op1_i != op2_i);
            B_LT:    cond_o = ($signed(op1_i) < $signed(op2_i));
            B_GE:    cond_o = ($signed(op1_i) >= $signed(op2_i));
            B_LTU:   cond_o = (op1_i < op2_i);
            B_GEU:   cond_o = (op1_i >= op2_i);
            default: cond_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/exec_writeback.sv
// Execute/write-back stage: ALU write-back, branch resolution and a single
// outstanding load. All outputs come straight from registers.
module exec_writeback
    import exec_writeback_pkg::*;
(
    input  logic            CLK,
    input  logic            reset,
    exec_writeback_if.slave bus,
    output state_t          dbg_state_o
);
    state_t          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic [XLEN-1:0] ld_data_q, ld_data_d;
    logic            wb_en_q, wb_en_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_value_q, wb_value_d;
    logic            br_taken_q, br_taken_d;
    logic [XLEN-1:0] br_target_q, br_target_d;
    logic [XLEN-1:0] alu_result;
    logic            alu_cond;

    exec_alu u_alu (
        .funct3_i   (bus.funct3),
        .funct7_5_i (bus.funct7[5]),
        .imm_flag_i (bus.imm_flag),
        .op1_i      (bus.op1),
        .op2_i      (bus.op2),
        .result_o   (alu_result),
        .cond_o     (alu_cond)
    );

    // Next state and next register values; pulses default low each cycle
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        ld_rd_d     = ld_rd_q;
        ld_data_d   = ld_data_q;
        wb_en_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_value_d  = wb_value_q;
        br_taken_d  = 1'b0;
        br_target_d = br_target_q;
        case (state_q)
            IDLE: begin
                if (bus.load_flag) begin
                    mem_addr_d = bus.op1 + bus.op2;
                    mem_req_d  = 1'b1;
                    ld_rd_d    = bus.rd;
                    state_d    = MEM_WAIT;
                end else if (bus.branch_flag) begin
                    br_taken_d  = alu_cond;
                    br_target_d = bus.PC_i + bus.branch_offset;
                end else if (bus.write_back && !bus.mem_acc) begin
                    wb_en_d    = (bus.rd != 5'd0);
                    wb_rd_d    = bus.rd;
                    wb_value_d = alu_result;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ack) begin
                    ld_data_d = bus.mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = MEM_WB;
                end
            end
            MEM_WB: begin
                wb_en_d    = (ld_rd_q != 5'd0);
                wb_rd_d    = ld_rd_q;
                wb_value_d = ld_data_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight load
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            ld_rd_q     <= '0;
            ld_data_q   <= '0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_value_q  <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            ld_rd_q     <= ld_rd_d;
            ld_data_q   <= ld_data_d;
            wb_en_q     <= wb_en_d;
            wb_rd_q     <= wb_rd_d;
            wb_value_q  <= wb_value_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
        end
    end

    assign bus.mem_req       = mem_req_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.ex_busy       = (state_q == MEM_WAIT);
    assign bus.wb_en         = wb_en_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_value      = wb_value_q;
    assign bus.branch_taken  = br_taken_q;
    assign bus.branch_target = br_target_q;
    assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_exec_writeback.sv
// Bench for exec_writeback: directed vectors from the stage description
// plus randomized ALU, branch and load traffic against a behavioural model.
module tb_exec_writeback;
    import exec_writeback_pkg::*;

    logic   CLK;
    logic   reset;
    state_t dbg_state;
    int     total = 0;
    int     bad   = 0;

    exec_writeback_if bus();

    exec_writeback dut (
        .CLK         (CLK),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Clock and reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        imm;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } alu_vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] pc;
        logic [63:0] off;
        logic        taken;
        logic [63:0] target;
    } br_vec_t;

    // ---------------- reference model ----------------
    function automatic logic [63:0] pow2(input int unsigned n);
        logic [63:0] p = 64'd1;
        for (int i = 0; i < int'(n); i++) p = p * 64'd2;
        return p;
    endfunction

    function automatic logic [63:0] ref_alu(input logic [2:0] f3, input logic f7b5,
                                            input logic imm, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [63:0] p;
        logic        sra;
        p   = pow2(int'(b[5:0]));
        sra = imm ? b[10] : f7b5;
        case (f3)
            3'd0: return (!imm && f7b5) ? a + (~b + 64'd1) : a + b;
            3'd1: return a * p;
            3'd2: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd3: return (a < b) ? 64'd1 : 64'd0;
            3'd4: return a ^ b;
            3'd5: return (sra && a[63]) ? ~((~a) / p) : a / p;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic ref_branch(input logic [2:0] f3, input logic [63:0] a,
                                        input logic [63:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_bubble();
        bus.write_back    = 1'b0;
        bus.imm_flag      = 1'b0;
        bus.mem_acc       = 1'b0;
        bus.load_flag     = 1'b0;
        bus.branch_flag   = 1'b0;
        bus.rd            = 5'd0;
        bus.funct3        = 3'd0;
        bus.funct7        = 7'd0;
        bus.op1           = rand64();
        bus.op2           = rand64();
        bus.branch_offset = rand64();
        bus.PC_i          = rand64();
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [2:0] f3, input logic [6:0] f7,
                             input logic imm, input logic [63:0] a, input logic [63:0] b);
        drive_bubble();
        bus.write_back = 1'b1;
        bus.imm_flag   = imm;
        bus.rd         = rd;
        bus.funct3     = f3;
        bus.funct7     = f7;
        bus.op1        = a;
        bus.op2        = b;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [63:0] a, input logic [63:0] b);
        drive_bubble();
        bus.write_back = 1'b1;
        bus.imm_flag   = 1'b1;
        bus.mem_acc    = 1'b1;
        bus.load_flag  = 1'b1;
        bus.rd         = rd;
        bus.funct3     = 3'($urandom_range(0, 7));
        bus.op1        = a;
        bus.op2        = b;
    endtask

    task automatic drive_branch(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] pc, input logic [63:0] off);
        drive_bubble();
        bus.branch_flag   = 1'b1;
        bus.funct3        = f3;
        bus.op1           = a;
        bus.op2           = b;
        bus.PC_i          = pc;
        bus.branch_offset = off;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset         = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        drive_bubble();
        repeat (2) @(posedge CLK);
        #1;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
        total++; if (bus.mem_addr !== 64'd0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
        total++; if (bus.ex_busy !== 1'b0) begin bad++; $display("FAIL reset_ex_busy got=%b exp=0", bus.ex_busy); end
        total++; if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL reset_wb_en got=%b exp=0", bus.wb_en); end
        total++; if (bus.wb_rd !== 5'd0) begin bad++; $display("FAIL reset_wb_rd got=%h exp=0", bus.wb_rd); end
        total++; if (bus.wb_value !== 64'd0) begin bad++; $display("FAIL reset_wb_value got=%h exp=0", bus.wb_value); end
        total++; if (bus.branch_taken !== 1'b0) begin bad++; $display("FAIL reset_br_taken got=%b exp=0", bus.branch_taken); end
        total++; if (bus.branch_target !== 64'd0) begin bad++; $display("FAIL reset_br_target got=%h exp=0", bus.branch_target); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
        @(negedge CLK);
        reset = 1'b1;
    endtask

    task automatic test_alu_directed();
        alu_vec_t v[8];
        logic [4:0] r;
        v[0] = '{3'b000, 7'h00, 1'b0, 64'd5, 64'd7, 64'd12};
        v[1] = '{3'b000, 7'h20, 1'b0, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE};
        v[2] = '{3'b101, 7'h00, 1'b1, 64'h8000_0000_0000_0000, 64'h404, 64'hF800_0000_0000_0000};
        v[3] = '{3'b011, 7'h00, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
        v[4] = '{3'b010, 7'h00, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        v[5] = '{3'b000, 7'h20, 1'b1, 64'd5, 64'd7, 64'd12};
        v[6] = '{3'b101, 7'h00, 1'b1, 64'h8000_0000_0000_0000, 64'h004, 64'h0800_0000_0000_0000};
        v[7] = '{3'b000, 7'h00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
        for (int i = 0; i < 8; i++) begin
            r = (i == 0) ? 5'd3 : 5'(i + 1);
            @(negedge CLK);
            drive_alu(r, v[i].f3, v[i].f7, v[i].imm, v[i].a, v[i].b);
            @(posedge CLK);
            #1;
            total++; if (bus.wb_en !== 1'b1) begin bad++; $display("FAIL alu_dir%0d_wb_en got=%b exp=1", i, bus.wb_en); end
            total++; if (bus.wb_rd !== r) begin bad++; $display("FAIL alu_dir%0d_wb_rd got=%0d exp=%0d", i, bus.wb_rd, r); end
            total++; if (bus.wb_value !== v[i].exp) begin bad++; $display("FAIL alu_dir%0d_value got=%h exp=%h", i, bus.wb_value, v[i].exp); end
            @(negedge CLK);
            drive_bubble();
            @(posedge CLK);
            #1;
            total++; if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL alu_dir%0d_pulse got=%b exp=0", i, bus.wb_en); end
        end
    endtask

    // Consecutive random ALU ops, expected results queued in issue order
    task automatic test_back_to_back();
        logic [63:0] exp_q[$];
        logic [4:0]  exp_rd_q[$];
        logic [4:0]  r, er;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        imm;
        logic [63:0] a, b, ev;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            r   = 5'($urandom_range(0, 31));
            f3  = 3'($urandom_range(0, 7));
            f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            imm = 1'($urandom_range(0, 1));
            a   = rand64();
            b   = rand64();
            if ($urandom_range(0, 3) == 0) a = {1'b1, a[62:0]};
            drive_alu(r, f3, f7, imm, a, b);
            exp_q.push_back(ref_alu(f3, f7[5], imm, a, b));
            exp_rd_q.push_back(r);
            @(posedge CLK);
            #1;
            ev = exp_q.pop_front();
            er = exp_rd_q.pop_front();
            total++; if (bus.wb_en !== (er != 5'd0)) begin bad++; $display("FAIL b2b%0d_wb_en got=%b exp=%b", i, bus.wb_en, er != 5'd0); end
            if (er != 5'd0) begin
                total++; if (bus.wb_rd !== er) begin bad++; $display("FAIL b2b%0d_wb_rd got=%0d exp=%0d", i, bus.wb_rd, er); end
                total++; if (bus.wb_value !== ev) begin bad++; $display("FAIL b2b%0d_value f3=%0d got=%h exp=%h", i, f3, bus.wb_value, ev); end
            end
        end
        @(negedge CLK);
        drive_bubble();
    endtask

    task automatic test_branch();
        br_vec_t v[7];
        logic [2:0]  f3;
        logic [63:0] a, b, pc, off;
        logic        et;
        v[0] = '{3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h100, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 64'hF0};
        v[1] = '{3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h100, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 64'h0};
        v[2] = '{3'b010, 64'd5, 64'd5, 64'h100, 64'h8, 1'b0, 64'h0};
        v[3] = '{3'b000, 64'd7, 64'd7, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1'b1, 64'h10};
        v[4] = '{3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2000, 64'h8, 1'b1, 64'h2008};
        v[5] = '{3'b111, 64'd0, 64'd1, 64'h40, 64'h8, 1'b0, 64'h0};
        v[6] = '{3'b001, 64'd3, 64'd4, 64'h0, 64'h4, 1'b1, 64'h4};
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            drive_branch(v[i].f3, v[i].a, v[i].b, v[i].pc, v[i].off);
            @(posedge CLK);
            #1;
            total++; if (bus.branch_taken !== v[i].taken) begin bad++; $display("FAIL br_dir%0d_taken got=%b exp=%b", i, bus.branch_taken, v[i].taken); end
            if (v[i].taken) begin
                total++; if (bus.branch_target !== v[i].target) begin bad++; $display("FAIL br_dir%0d_target got=%h exp=%h", i, bus.branch_target, v[i].target); end
            end
            total++; if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL br_dir%0d_no_wb got=%b exp=0", i, bus.wb_en); end
            @(negedge CLK);
            drive_bubble();
            @(posedge CLK);
            #1;
            total++; if (bus.branch_taken !== 1'b0) begin bad++; $display("FAIL br_dir%0d_pulse got=%b exp=0", i, bus.branch_taken); end
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            f3  = 3'($urandom_range(0, 7));
            a   = rand64();
            b   = ($urandom_range(0, 3) == 0) ? a : rand64();
            pc  = rand64();
            off = rand64();
            et  = ref_branch(f3, a, b);
            drive_branch(f3, a, b, pc, off);
            @(posedge CLK);
            #1;
            total++; if (bus.branch_taken !== et) begin bad++; $display("FAIL br_rnd%0d_taken f3=%0d got=%b exp=%b", i, f3, bus.branch_taken, et); end
            if (et) begin
                total++; if (bus.branch_target !== pc + off) begin bad++; $display("FAIL br_rnd%0d_target got=%h exp=%h", i, bus.branch_target, pc + off); end
            end
        end
        @(negedge CLK);
        drive_bubble();
    endtask

    task automatic test_load();
        logic [63:0] a, b, data, addr;
        logic [4:0]  r;
        int          waits;
        for (int n = 0; n < 8; n++) begin
            if (n == 0) begin
                a = 64'h1000; b = 64'hFFFF_FFFF_FFFF_FFF8; r = 5'd5; waits = 3; data = 64'hDEAD_BEEF;
            end else begin
                a = rand64(); b = rand64(); data = rand64();
                r = (n == 1) ? 5'd0 : 5'($urandom_range(1, 31));
                waits = $urandom_range(0, 3);
            end
            addr = (n == 0) ? 64'hFF8 : a + b;
            @(negedge CLK);
            drive_load(r, a, b);
            bus.mem_ack = 1'b0;
            for (int k = 0; k <= waits; k++) begin
                @(posedge CLK);
                #1;
                total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL ld%0d_req_c%0d got=%b exp=1", n, k, bus.mem_req); end
                total++; if (bus.mem_addr !== addr) begin bad++; $display("FAIL ld%0d_addr_c%0d got=%h exp=%h", n, k, bus.mem_addr, addr); end
                total++; if (bus.ex_busy !== 1'b1) begin bad++; $display("FAIL ld%0d_busy_c%0d got=%b exp=1", n, k, bus.ex_busy); end
                total++; if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL ld%0d_early_wb_c%0d got=%b exp=0", n, k, bus.wb_en); end
                @(negedge CLK);
                drive_alu(5'($urandom_range(1, 31)), 3'($urandom_range(0, 7)), 7'h00, 1'b0, rand64(), rand64());
                bus.mem_ack   = (k == waits);
                bus.mem_rdata = (k == waits) ? data : rand64();
            end
            @(posedge CLK);
            #1;
            total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL ld%0d_req_drop got=%b exp=0", n, bus.mem_req); end
            total++; if (bus.ex_busy !== 1'b0) begin bad++; $display("FAIL ld%0d_busy_drop got=%b exp=0", n, bus.ex_busy); end
            total++; if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL ld%0d_wb_ackcyc got=%b exp=0", n, bus.wb_en); end
            @(negedge CLK);
            drive_bubble();
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = rand64();
            @(posedge CLK);
            #1;
            total++; if (bus.wb_en !== (r != 5'd0)) begin bad++; $display("FAIL ld%0d_wb_en got=%b exp=%b", n, bus.wb_en, r != 5'd0); end
            if (r != 5'd0) begin
                total++; if (bus.wb_rd !== r) begin bad++; $display("FAIL ld%0d_wb_rd got=%0d exp=%0d", n, bus.wb_rd, r); end
                total++; if (bus.wb_value !== data) begin bad++; $display("FAIL ld%0d_wb_value got=%h exp=%h", n, bus.wb_value, data); end
            end
            @(posedge CLK);
            #1;
            total++; if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL ld%0d_wb_pulse got=%b exp=0", n, bus.wb_en); end
            total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL ld%0d_state got=%0d exp=%0d", n, dbg_state, IDLE); end
        end
    endtask

    task automatic test_rd0_and_spurious_ack();
        @(negedge CLK);
        drive_alu(5'd0, 3'b000, 7'h00, 1'b0, 64'd5, 64'd7);
        @(posedge CLK);
        #1;
        total++; if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL rd0_add_wb_en got=%b exp=0", bus.wb_en); end
        @(negedge CLK);
        drive_bubble();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rand64();
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL spur%0d_req got=%b exp=0", i, bus.mem_req); end
            total++; if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL spur%0d_wb_en got=%b exp=0", i, bus.wb_en); end
            total++; if (bus.ex_busy !== 1'b0) begin bad++; $display("FAIL spur%0d_busy got=%b exp=0", i, bus.ex_busy); end
            total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL spur%0d_state got=%0d exp=%0d", i, dbg_state, IDLE); end
        end
        @(negedge CLK);
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        @(negedge CLK);
        drive_load(5'd9, 64'h2000, 64'h10);
        bus.mem_ack = 1'b0;
        @(posedge CLK);
        #1;
        total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL rstw_req_before got=%b exp=1", bus.mem_req); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rstw_req_async got=%b exp=0", bus.mem_req); end
        total++; if (bus.ex_busy !== 1'b0) begin bad++; $display("FAIL rstw_busy_async got=%b exp=0", bus.ex_busy); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rstw_state got=%0d exp=%0d", dbg_state, IDLE); end
        @(negedge CLK);
        reset = 1'b1;
        drive_bubble();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            total++; if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL rstw%0d_wb_en got=%b exp=0", i, bus.wb_en); end
            total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rstw%0d_req got=%b exp=0", i, bus.mem_req); end
        end
        @(negedge CLK);
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_directed();
        test_back_to_back();
        test_branch();
        test_load();
        test_rd0_and_spurious_ack();
        test_reset_in_wait();
        repeat (2) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exec_writeback.md
# exec_writeback

Execute/write-back stage of the 64-bit RV64I pipeline: consumes the operand bundle produced by instruction decode, performs ALU ops, resolves branches, runs a single-outstanding load transaction against data memory, and drives the `wb_rd`/`wb_value`/`wb_en` write-back port that decode uses for its register file and operand bypass.

## Interface
- `XLEN`, 64, datapath width
- `CLK` input 1: single clock, all state on rising edge
- `reset` input 1: asynchronous, active-low
- `rd`, `funct3`, `funct7` input 5/3/7: decoded fields
- `op1`, `op2` input 64: operands; `op2` is the sign-extended immediate when `imm_flag`=1
- `write_back`, `imm_flag`, `mem_acc`, `load_flag`, `branch_flag` input 1 each: decoded class flags
- `branch_offset`, `PC_i` input 64: branch displacement and instruction PC
- `mem_req` output 1, `mem_addr` output 64, `mem_rdata` input 64, `mem_ack` input 1: load handshake
- `wb_rd` output 5, `wb_value` output 64, `wb_en` output 1: write-back port
- `branch_taken` output 1, `branch_target` output 64: branch resolution
- `ex_busy` output 1: load in flight, upstream must hold

## Operation
- Reset (async, `reset`=0): all outputs 0, FSM to IDLE; an in-flight load is abandoned, no write-back.
- FSM states: IDLE, MEM_WAIT, MEM_WB.
- IDLE, `write_back`=1, `mem_acc`=0: ALU result written; `wb_en`=1 unless `rd`=0.
- ALU (`funct3`): 000 ADD (SUB if `!imm_flag && funct7[5]`), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if `funct7[5]` for register form, `op2[10]` for immediate form), 110 OR, 111 AND. Shift amount `op2[5:0]`; all arithmetic modulo 2^64; SLT/SLTU yield 0 or 1.
- IDLE, `load_flag`=1: register `mem_addr`=`op1`+`op2`, `mem_req`=1, `ex_busy`=1, latch `rd`, go MEM_WAIT.
- MEM_WAIT: hold `mem_req`/`mem_addr` stable until `mem_ack`=1; on ack capture `mem_rdata`, drop `mem_req`, go MEM_WB. Loads return the full 64-bit `mem_rdata`; `funct3` ignored.
- MEM_WB: `wb_en`=1 (unless latched `rd`=0), `wb_value`=captured data, `ex_busy`=0, return to IDLE.
- `mem_ack` outside MEM_WAIT ignored. Decode inputs ignored while not IDLE.
- IDLE, `branch_flag`=1: compare `op1`/`op2` per `funct3`: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 never taken. `branch_taken` pulses 1 cycle; `branch_target`=`PC_i`+`branch_offset` (wraps mod 2^64). No write-back.
- All-zero flags (bubble/NOP from stall): no outputs asserted.

## Timing
- Decode updates its outputs on falling edge; this block samples on the following rising edge.
- ALU: `wb_*` valid 1 cycle after sampling edge, `wb_en` is a single-cycle pulse per instruction.
- Branch: `branch_taken`/`branch_target` registered, 1-cycle latency, 1-cycle pulse.
- Load: `mem_req` rises 1 cycle after sampling; ack earliest the cycle `mem_req` is high; `wb_en` 1 cycle after ack cycle. Zero-wait memory: 3 cycles sample-to-`wb_en`.
- `ex_busy` high from `mem_req` rise through the ack cycle inclusive.
- Back-to-back ALU ops: one `wb_en` per cycle, no bubbles.

## Structure
- Shared package: opcode constants (ALGORITHM, ALGORITHM_IMM, LOAD, BRANCH), ALU and branch `funct3` encodings, FSM state encoding.
- Sub-module `exec_alu`: combinational ALU + branch comparator (`funct3`, `funct7[5]`, `imm_flag`, `op1`, `op2` -> result, cond). Top holds FSM, memory handshake and output registers.

## Test plan
- ADD `op1`=5, `op2`=7, `rd`=3 -> next cycle `wb_en`=1, `wb_rd`=3, `wb_value`=12; SUB 5-7 -> 0xFFFF_FFFF_FFFF_FFFE.
- SRAI `op1`=0x8000_0000_0000_0000, `op2`=0x404 -> 0xF800_0000_0000_0000; SLTU 1 vs 0xFFFF...F -> 1, SLT -> 0.
- Load `op1`=0x1000, `op2`=-8, `mem_ack` after 3 wait cycles, `mem_rdata`=0xDEAD_BEEF -> `mem_addr`=0xFF8, `mem_req` held 4 cycles, `ex_busy` high, single `wb_en` with 0xDEAD_BEEF.
- BLT `op1`=-1, `op2`=0, `PC_i`=0x100, `branch_offset`=-16 -> `branch_taken`=1, target 0xF0; BLTU same operands -> not taken; `funct3`=010 -> not taken.
- `rd`=0 ADD and `rd`=0 load -> `wb_en` stays 0; spurious `mem_ack` in IDLE -> no effect.
- `reset` low in MEM_WAIT -> `mem_req`, `ex_busy` drop immediately; later `mem_ack` produces no write-back.
